hazard_unit: RTL and testbench

- Consumer of the per-instruction hazard descriptors (Tuse/Tnew/read/write addresses) produced by the D-stage instruction classifier.
- Keeps E/M/W shadow copies of those descriptors and drives the D-stage stall plus the forwarding-mux selects for D and E operands.
- Also owns the HI/LO multiply/divide busy timer that stalls mult/div/mf/mt instructions.
- Sits beside the 5-stage datapath; all outputs are combinational from inputs plus internal shadow registers.

---
 rtl/hazard_unit_pkg.sv | 54 +++++
 rtl/hazard_unit_md_busy_timer.sv | 48 ++++
 rtl/hazard_unit.sv | 141 ++++++++++++++
 tb/tb_hazard_unit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit_pkg
//  Description : Shared types and constants for the hazard unit: forwarding
//                select encodings, mult/div kind encodings, default HI/LO
//                latencies, shadow-register layouts and their bubble values.
//  Revision    : 1.0  initial release
// ============================================================================
package hazard_unit_pkg;

    // Operand source select for the D and E forwarding muxes.
    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2,
        FWD_W  = 2'd3
    } fwd_sel_t;

    // Class of HI/LO unit usage carried with each instruction.
    typedef enum logic [1:0] {
        MD_NONE = 2'd0,
        MD_MULT = 2'd1,
        MD_DIV  = 2'd2,
        MD_HILO = 2'd3
    } md_kind_t;

    localparam int c_MULT_CYCLES_DEF = 5;
    localparam int c_DIV_CYCLES_DEF  = 10;

    // E-stage shadow: everything needed for stall, E forwarding and the timer.
    typedef struct packed {
        logic [4:0] ra1;
        logic [4:0] ra2;
        logic [4:0] wa;
        logic [1:0] tnew;
        md_kind_t   md_kind;
    } e_shadow_t;

    // M/W shadows only need the producer side.
    typedef struct packed {
        logic [4:0] wa;
        logic [1:0] tnew;
    } mw_shadow_t;

    localparam e_shadow_t  c_E_BUBBLE  = '0;
    localparam mw_shadow_t c_MW_BUBBLE = '0;

    // Remaining-latency decrement, floored at zero.
    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_unit_md_busy_timer.sv
`default_nettype none
// ============================================================================
//  Module      : md_busy_timer
//  Description : HI/LO busy timer. Loads the mult or div latency on the edge
//                an operation leaves E (unless flushed), otherwise counts
//                down to zero. Busy while the count is nonzero.
//  Ports       : clk, reset_n (async, active-low)
//                i_flush     - pipeline flush; suppresses a load only
//                i_md_kind_e - md kind of the instruction currently in E
//                o_busy      - HI/LO result not yet available
//  Revision    : 1.0  initial release
// ============================================================================
module md_busy_timer
    import hazard_unit_pkg::*;
#(
    parameter int MULT_CYCLES = c_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = c_DIV_CYCLES_DEF
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     i_flush,
    input  md_kind_t i_md_kind_e,
    output logic     o_busy
);

    localparam int c_MAX   = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W = $clog2(c_MAX + 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (!i_flush && (i_md_kind_e == MD_MULT)) begin
            r_cnt <= c_CNT_W'(MULT_CYCLES);
        end else if (!i_flush && (i_md_kind_e == MD_DIV)) begin
            r_cnt <= c_CNT_W'(DIV_CYCLES);
        end else if (r_cnt != '0) begin
            // A flushed mult/div never started, but one already running
            // keeps counting through the flush.
            r_cnt <= r_cnt - c_CNT_W'(1);
        end
    end

    assign o_busy = (r_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit
//  Description : Pipeline hazard unit. Tracks E/M/W shadows of the Tuse/Tnew
//                hazard descriptors, raises the D-stage stall, and drives the
//                D and E operand forwarding selects. Owns the HI/LO timer.
//  Ports       : clk, reset_n (async, active-low)
//                d_tuse1/2, d_ra1/2, d_tnew, d_wa, d_md_kind - D descriptor
//                flush   - turn every shadow into a bubble
//                stall   - freeze PC/D, bubble into E
//                fwd_d1/2 - D operand source (RF/E/M/W)
//                fwd_e1/2 - E operand source (ID/EX, M, W)
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int MULT_CYCLES = c_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = c_DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] d_tuse1,
    input  logic [1:0] d_tuse2,
    input  logic [4:0] d_ra1,
    input  logic [4:0] d_ra2,
    input  logic [1:0] d_tnew,
    input  logic [4:0] d_wa,
    input  logic [1:0] d_md_kind,
    input  logic       flush,
    output logic       stall,
    output logic [1:0] fwd_d1,
    output logic [1:0] fwd_d2,
    output logic [1:0] fwd_e1,
    output logic [1:0] fwd_e2
);

    e_shadow_t  r_e;
    mw_shadow_t r_m;
    mw_shadow_t r_w;

    logic w_hazard;
    logic w_md_stall;
    logic w_busy;

    // Consumer needs the value in tuse cycles, producer delivers in tnew.
    function automatic logic raw_hz(input logic [4:0] ra, input logic [1:0] tuse,
                                    input logic [4:0] wa, input logic [1:0] tnew);
        return (ra != 5'd0) && (ra == wa) && (tnew > tuse);
    endfunction

    // The youngest matching stage owns the register; if its value is not
    // ready, older stages hold stale data, so fall back to the RF path.
    function automatic fwd_sel_t sel_d(input logic [4:0] ra,
                                       input mw_shadow_t e, input mw_shadow_t m,
                                       input mw_shadow_t w);
        fwd_sel_t sel;
        sel = FWD_RF;
        if (ra != 5'd0) begin
            if (ra == e.wa) begin
                if (e.tnew == 2'd0) sel = FWD_E;
            end else if (ra == m.wa) begin
                if (m.tnew == 2'd0) sel = FWD_M;
            end else if (ra == w.wa) begin
                if (w.tnew == 2'd0) sel = FWD_W;
            end
        end
        return sel;
    endfunction

    function automatic fwd_sel_t sel_e(input logic [4:0] ra,
                                       input mw_shadow_t m, input mw_shadow_t w);
        fwd_sel_t sel;
        sel = FWD_RF;
        if (ra != 5'd0) begin
            if (ra == m.wa) begin
                if (m.tnew == 2'd0) sel = FWD_M;
            end else if (ra == w.wa) begin
                if (w.tnew == 2'd0) sel = FWD_W;
            end
        end
        return sel;
    endfunction

    mw_shadow_t w_e_prod;
    assign w_e_prod = '{wa: r_e.wa, tnew: r_e.tnew};

    assign w_hazard = raw_hz(d_ra1, d_tuse1, r_e.wa, r_e.tnew)
                    | raw_hz(d_ra2, d_tuse2, r_e.wa, r_e.tnew)
                    | raw_hz(d_ra1, d_tuse1, r_m.wa, r_m.tnew)
                    | raw_hz(d_ra2, d_tuse2, r_m.wa, r_m.tnew);

    // Any HI/LO user waits while a mult/div is in E or still computing.
    assign w_md_stall = (d_md_kind != MD_NONE)
                      && ((r_e.md_kind == MD_MULT) || (r_e.md_kind == MD_DIV) || w_busy);

    assign stall  = w_hazard | w_md_stall;
    assign fwd_d1 = sel_d(d_ra1, w_e_prod, r_m, r_w);
    assign fwd_d2 = sel_d(d_ra2, w_e_prod, r_m, r_w);
    assign fwd_e1 = sel_e(r_e.ra1, r_m, r_w);
    assign fwd_e2 = sel_e(r_e.ra2, r_m, r_w);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_e <= c_E_BUBBLE;
            r_m <= c_MW_BUBBLE;
            r_w <= c_MW_BUBBLE;
        end else if (flush) begin
            r_e <= c_E_BUBBLE;
            r_m <= c_MW_BUBBLE;
            r_w <= c_MW_BUBBLE;
        end else begin
            if (stall) begin
                r_e <= c_E_BUBBLE;
            end else begin
                r_e.ra1     <= d_ra1;
                r_e.ra2     <= d_ra2;
                r_e.wa      <= d_wa;
                r_e.tnew    <= sat_dec(d_tnew);
                r_e.md_kind <= md_kind_t'(d_md_kind);
            end
            r_m.wa   <= r_e.wa;
            r_m.tnew <= sat_dec(r_e.tnew);
            r_w.wa   <= r_m.wa;
            r_w.tnew <= sat_dec(r_m.tnew);
        end
    end

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_flush     (flush),
        .i_md_kind_e (r_e.md_kind),
        .o_busy      (w_busy)
    );

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_unit
//  Description : Self-checking bench for hazard_unit. A reference model
//                tracks each in-flight instruction by its original Tnew and
//                its pipeline depth, and HI/LO availability as a ready cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_unit;

    localparam int c_MULT = 5;
    localparam int c_DIV  = 10;

    logic       clk;
    logic       reset_n;
    logic [1:0] d_tuse1, d_tuse2, d_tnew, d_md_kind;
    logic [4:0] d_ra1, d_ra2, d_wa;
    logic       flush;
    logic       stall;
    logic [1:0] fwd_d1, fwd_d2, fwd_e1, fwd_e2;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_unit #(
        .MULT_CYCLES (c_MULT),
        .DIV_CYCLES  (c_DIV)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .d_tuse1   (d_tuse1),
        .d_tuse2   (d_tuse2),
        .d_ra1     (d_ra1),
        .d_ra2     (d_ra2),
        .d_tnew    (d_tnew),
        .d_wa      (d_wa),
        .d_md_kind (d_md_kind),
        .flush     (flush),
        .stall     (stall),
        .fwd_d1    (fwd_d1),
        .fwd_d2    (fwd_d2),
        .fwd_e1    (fwd_e1),
        .fwd_e2    (fwd_e2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        int ra1;
        int ra2;
        int wa;
        int tnew0;   // Tnew as issued in D
        int md;
    } minst_t;

    minst_t mE, mM, mW;
    int     cyc;
    int     hilo_ready;  // first cycle count at which HI/LO is free

    // Cycles still to wait for an instruction that is 'depth' stages past D.
    function automatic int rem(input minst_t s, input int depth);
        return (s.tnew0 > depth) ? s.tnew0 - depth : 0;
    endfunction

    function automatic bit m_stall();
        bit s;
        int ra[2];
        int tu[2];
        ra[0] = d_ra1; ra[1] = d_ra2;
        tu[0] = d_tuse1; tu[1] = d_tuse2;
        s = 0;
        for (int i = 0; i < 2; i++) begin
            if (ra[i] != 0 && ra[i] == mE.wa && rem(mE, 1) > tu[i]) s = 1;
            if (ra[i] != 0 && ra[i] == mM.wa && rem(mM, 2) > tu[i]) s = 1;
        end
        if (d_md_kind != 0 && (mE.md == 1 || mE.md == 2 || cyc < hilo_ready)) s = 1;
        return s;
    endfunction

    function automatic int m_fwd_d(input int ra);
        if (ra == 0) return 0;
        if (ra == mE.wa) return (rem(mE, 1) == 0) ? 1 : 0;
        if (ra == mM.wa) return (rem(mM, 2) == 0) ? 2 : 0;
        if (ra == mW.wa) return (rem(mW, 3) == 0) ? 3 : 0;
        return 0;
    endfunction

    function automatic int m_fwd_e(input int ra);
        if (ra == 0) return 0;
        if (ra == mM.wa) return (rem(mM, 2) == 0) ? 2 : 0;
        if (ra == mW.wa) return (rem(mW, 3) == 0) ? 3 : 0;
        return 0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mE         <= '{0, 0, 0, 0, 0};
            mM         <= '{0, 0, 0, 0, 0};
            mW         <= '{0, 0, 0, 0, 0};
            cyc        <= 0;
            hilo_ready <= 0;
        end else begin
            cyc <= cyc + 1;
            if (!flush && mE.md == 1) hilo_ready <= cyc + 1 + c_MULT;
            else if (!flush && mE.md == 2) hilo_ready <= cyc + 1 + c_DIV;
            if (flush) begin
                mE <= '{0, 0, 0, 0, 0};
                mM <= '{0, 0, 0, 0, 0};
                mW <= '{0, 0, 0, 0, 0};
            end else begin
                mW <= mM;
                mM <= mE;
                if (m_stall()) mE <= '{0, 0, 0, 0, 0};
                else mE <= '{int'(d_ra1), int'(d_ra2), int'(d_wa), int'(d_tnew), int'(d_md_kind)};
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        n_tests++;
        if (stall !== m_stall()) begin
            n_fail++;
            $display("FAIL cmp_stall t=%0t got %0d want %0d", $time, stall, m_stall());
        end
        n_tests++;
        if (int'(fwd_d1) != m_fwd_d(d_ra1) || $isunknown(fwd_d1)) begin
            n_fail++;
            $display("FAIL cmp_fwd_d1 t=%0t got %0d want %0d", $time, fwd_d1, m_fwd_d(d_ra1));
        end
        n_tests++;
        if (int'(fwd_d2) != m_fwd_d(d_ra2) || $isunknown(fwd_d2)) begin
            n_fail++;
            $display("FAIL cmp_fwd_d2 t=%0t got %0d want %0d", $time, fwd_d2, m_fwd_d(d_ra2));
        end
        n_tests++;
        if (int'(fwd_e1) != m_fwd_e(mE.ra1) || $isunknown(fwd_e1)) begin
            n_fail++;
            $display("FAIL cmp_fwd_e1 t=%0t got %0d want %0d", $time, fwd_e1, m_fwd_e(mE.ra1));
        end
        n_tests++;
        if (int'(fwd_e2) != m_fwd_e(mE.ra2) || $isunknown(fwd_e2)) begin
            n_fail++;
            $display("FAIL cmp_fwd_e2 t=%0t got %0d want %0d", $time, fwd_e2, m_fwd_e(mE.ra2));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // Present one D descriptor for one cycle; returns at the following negedge.
    task automatic issue(input logic [4:0] ra1, input logic [1:0] tu1,
                         input logic [4:0] ra2, input logic [1:0] tu2,
                         input logic [1:0] tnew, input logic [4:0] wa,
                         input logic [1:0] md, input logic fl);
        @(posedge clk);
        #1;
        d_ra1 = ra1; d_tuse1 = tu1; d_ra2 = ra2; d_tuse2 = tu2;
        d_tnew = tnew; d_wa = wa; d_md_kind = md; flush = fl;
        @(negedge clk);
    endtask

    task automatic nop();
        issue(5'd0, 2'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got timeout want completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 1'b0;
        d_ra1 = '0; d_tuse1 = '0; d_ra2 = '0; d_tuse2 = '0;
        d_tnew = '0; d_wa = '0; d_md_kind = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_fwd_d1", fwd_d1, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        nop();
        chk("idle_stall", stall, 0);
        chk("idle_fwd_e1", fwd_e1, 0);

        // ALU -> ALU
        issue(5'd1, 2'd1, 5'd2, 2'd1, 2'd2, 5'd3, 2'd0, 1'b0);  // addu $3
        issue(5'd3, 2'd1, 5'd0, 2'd0, 2'd2, 5'd4, 2'd0, 1'b0);  // reader of $3
        chk("alu_stall", stall, 0);
        chk("alu_fwd_d1", fwd_d1, 0);
        nop();
        chk("alu_fwd_e1", fwd_e1, 2);

        // Load-use: two stall cycles, then W supplies the value
        issue(5'd29, 2'd1, 5'd0, 2'd0, 2'd3, 5'd5, 2'd0, 1'b0); // lw $5
        issue(5'd5, 2'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0);  // beq $5
        chk("lu_stall0", stall, 1);
        chk("lu_fwd0", fwd_d1, 0);
        issue(5'd5, 2'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0);
        chk("lu_stall1", stall, 1);
        issue(5'd5, 2'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0);
        chk("lu_stall2", stall, 0);
        chk("lu_fwd_w", fwd_d1, 3);

        // jal then jr $31
        issue(5'd0, 2'd0, 5'd0, 2'd0, 2'd1, 5'd31, 2'd0, 1'b0);
        issue(5'd31, 2'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0);
        chk("jr_stall", stall, 0);
        chk("jr_fwd_e", fwd_d1, 1);

        // mult then mflo: 1 + MULT stall cycles
        issue(5'd8, 2'd1, 5'd9, 2'd1, 2'd0, 5'd0, 2'd1, 1'b0);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            issue(5'd0, 2'd0, 5'd0, 2'd0, 2'd1, 5'd10, 2'd3, 1'b0);
            if (stall) n++;
            else break;
        end
        chk("mult_stall_cycles", n, 6);

        // div then mfhi: 1 + DIV stall cycles
        issue(5'd8, 2'd1, 5'd9, 2'd1, 2'd0, 5'd0, 2'd2, 1'b0);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            issue(5'd0, 2'd0, 5'd0, 2'd0, 2'd1, 5'd11, 2'd3, 1'b0);
            if (stall) n++;
            else break;
        end
        chk("div_stall_cycles", n, 11);

        // Non-MD instructions proceed while HI/LO is busy
        issue(5'd8, 2'd1, 5'd9, 2'd1, 2'd0, 5'd0, 2'd1, 1'b0);  // mult
        issue(5'd0, 2'd0, 5'd0, 2'd0, 2'd2, 5'd12, 2'd0, 1'b0); // addu, mult in E
        chk("md_alu_stall_e", stall, 0);
        issue(5'd0, 2'd0, 5'd0, 2'd0, 2'd2, 5'd13, 2'd0, 1'b0); // addu, busy=5
        chk("md_alu_stall_busy", stall, 0);

        // Flush over a live load-use stall; timer keeps counting
        issue(5'd29, 2'd1, 5'd0, 2'd0, 2'd3, 5'd6, 2'd0, 1'b0); // lw $6, busy=4
        issue(5'd6, 2'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b1);  // beq $6 + flush
        chk("fl_stall_comb", stall, 1);
        issue(5'd6, 2'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0);
        chk("fl_stall_after", stall, 0);
        chk("fl_fwd_d1", fwd_d1, 0);
        issue(5'd0, 2'd0, 5'd0, 2'd0, 2'd1, 5'd10, 2'd3, 1'b0); // mflo, busy=1
        chk("fl_busy_last", stall, 1);
        issue(5'd0, 2'd0, 5'd0, 2'd0, 2'd1, 5'd10, 2'd3, 1'b0); // busy=0
        chk("fl_busy_done", stall, 0);

        // $0 writer then $0 reader
        issue(5'd1, 2'd1, 5'd0, 2'd0, 2'd2, 5'd0, 2'd0, 1'b0);
        issue(5'd0, 2'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0);
        chk("r0_stall", stall, 0);
        chk("r0_fwd_d1", fwd_d1, 0);

        // E and M both write $7: E owns it even though M is ready
        issue(5'd0, 2'd0, 5'd0, 2'd0, 2'd1, 5'd7, 2'd0, 1'b0);
        issue(5'd0, 2'd0, 5'd0, 2'd0, 2'd2, 5'd7, 2'd0, 1'b0);
        issue(5'd0, 2'd0, 5'd7, 2'd2, 2'd0, 5'd0, 2'd0, 1'b0);
        chk("own_stall", stall, 0);
        chk("own_fwd_d2", fwd_d2, 0);
        nop();
        chk("own_fwd_e2", fwd_e2, 2);

        // Mid-run asynchronous reset with a live stall
        issue(5'd29, 2'd1, 5'd0, 2'd0, 2'd3, 5'd5, 2'd0, 1'b0);
        issue(5'd5, 2'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0);
        chk("mr_stall_pre", stall, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mr_stall_rst", stall, 0);
        chk("mr_fwd_d1_rst", fwd_d1, 0);
        @(posedge clk); #1;
        d_ra1 = '0; d_tuse1 = '0; d_ra2 = '0; d_tuse2 = '0;
        d_tnew = '0; d_wa = '0; d_md_kind = '0; flush = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        chk("mr_stall_rel", stall, 0);
        nop();
        chk("mr_fwd_e1_rel", fwd_e1, 0);
        nop();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
